// File: rtl/regfile_write_scheduler_pkg.sv
// Shared core package for the register-file write scheduler.
// Holds the FSM state type and register-file geometry constants.
package regfile_write_scheduler_pkg;

  localparam int REG_CNT    = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/regfile_write_scheduler_arb.sv
// Two-way round-robin arbiter: a lone request always wins, a contended
// request pair is resolved by the pointer (0 selects req[0], 1 selects req[1]).
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: clears the external RAM after reset, then
// arbitrates two writeback sources onto one RAM write port with read bypass.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w0_valid,
  output logic                  w0_ready,
  input  logic [REG_ADDR_W-1:0] w0_addr,
  input  logic [WIDTH-1:0]      w0_data,
  input  logic                  w1_valid,
  output logic                  w1_ready,
  input  logic [REG_ADDR_W-1:0] w1_addr,
  input  logic [WIDTH-1:0]      w1_data,
  input  logic [REG_ADDR_W-1:0] r_addr0,
  input  logic [REG_ADDR_W-1:0] r_addr1,
  input  logic [REG_ADDR_W-1:0] r_addr2,
  output logic [WIDTH-1:0]      r_data0,
  output logic [WIDTH-1:0]      r_data1,
  output logic [WIDTH-1:0]      r_data2,
  output logic [REG_ADDR_W-1:0] ram_addr0,
  output logic [REG_ADDR_W-1:0] ram_addr1,
  output logic [REG_ADDR_W-1:0] ram_addr2,
  output logic [REG_ADDR_W-1:0] ram_addrw,
  output logic [WIDTH-1:0]      ram_din,
  output logic                  ram_wea,
  input  logic [WIDTH-1:0]      ram_dout0,
  input  logic [WIDTH-1:0]      ram_dout1,
  input  logic [WIDTH-1:0]      ram_dout2,
  output logic                  init_done
);

  sched_state_e          state, state_nxt;
  logic [REG_ADDR_W-1:0] sweep_cnt;
  logic                  rr_ptr;
  logic [1:0]            req, gnt;
  logic                  win_vld;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;

  // Requests are masked during the clear sweep so nothing is granted early.
  assign req = (state == ST_RUN) ? {w1_valid, w0_valid} : 2'b00;

  rr_arb2 u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign w0_ready  = gnt[0];
  assign w1_ready  = gnt[1];
  assign win_vld   = |gnt;
  assign win_addr  = gnt[1] ? w1_addr : w0_addr;
  assign win_data  = gnt[1] ? w1_data : w0_data;
  assign init_done = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
      if (req == 2'b11) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && sweep_cnt == REG_ADDR_W'(REG_CNT - 1)) begin
      state_nxt = ST_RUN;
    end
  end

  // Register 0 is hardwired to zero, so granted writes to it are dropped.
  always_comb begin
    ram_wea   = 1'b0;
    ram_addrw = win_addr;
    ram_din   = win_data;
    if (state == ST_INIT) begin
      ram_wea   = 1'b1;
      ram_addrw = sweep_cnt;
      ram_din   = '0;
    end else if (win_vld && win_addr != '0) begin
      ram_wea = 1'b1;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [REG_ADDR_W-1:0] addr,
                                                 input logic [WIDTH-1:0]      dout);
    logic [WIDTH-1:0] val;
    val = dout;
    if (state == ST_INIT || addr == '0) begin
      val = '0;
    end else if (win_vld && win_addr == addr) begin
      val = win_data;
    end
    return val;
  endfunction

  assign ram_addr0 = r_addr0;
  assign ram_addr1 = r_addr1;
  assign ram_addr2 = r_addr2;
  assign r_data0   = read_port(r_addr0, ram_dout0);
  assign r_data1   = read_port(r_addr1, ram_dout1);
  assign r_data2   = read_port(r_addr2, ram_dout2);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: hosts the external RAM, drives random and directed
// writes, and compares every cycle against a register-array reference model.
module tb_regfile_write_scheduler;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             w0_valid = 1'b0, w1_valid = 1'b0;
  logic             w0_ready, w1_ready;
  logic [4:0]       w0_addr = '0, w1_addr = '0;
  logic [WIDTH-1:0] w0_data = '0, w1_data = '0;
  logic [4:0]       r_addr0 = '0, r_addr1 = '0, r_addr2 = '0;
  logic [WIDTH-1:0] r_data0, r_data1, r_data2;
  logic [4:0]       ram_addr0, ram_addr1, ram_addr2, ram_addrw;
  logic [WIDTH-1:0] ram_din, ram_dout0, ram_dout1, ram_dout2;
  logic             ram_wea, init_done;

  int testsRun = 0;
  int testsFailed = 0;

  // reference model: architectural registers, sweep progress, rr pointer
  logic [WIDTH-1:0] modelRegs [32];
  int               modelSweep = 0;
  bit               modelPtr = 1'b0;
  bit               lastG0, lastG1;

  logic [WIDTH-1:0] ramMem [32];

  regfile_write_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_addr(w1_addr), .w1_data(w1_data),
    .r_addr0(r_addr0), .r_addr1(r_addr1), .r_addr2(r_addr2),
    .r_data0(r_data0), .r_data1(r_data1), .r_data2(r_data2),
    .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea),
    .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  assign ram_dout0 = ramMem[ram_addr0];
  assign ram_dout1 = ramMem[ram_addr1];
  assign ram_dout2 = ramMem[ram_addr2];

  // RAM starts with garbage so only the clear sweep can zero it
  initial begin
    for (int i = 0; i < 32; i++) ramMem[i] = $urandom;
    forever begin
      @(posedge clk);
      if (ram_wea) ramMem[ram_addrw] <= ram_din;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] modelRead(input logic [4:0] ra, input bit inInit,
                                                 input bit g, input logic [4:0] wa,
                                                 input logic [WIDTH-1:0] wd);
    if (inInit || ra == 5'd0) return '0;
    if (g && wa == ra) return wd;
    return modelRegs[ra];
  endfunction

  // compare DUT against model for the current cycle, then advance the model
  task automatic compareCycle();
    bit inInit, g;
    logic [4:0] wa;
    logic [WIDTH-1:0] wd;
    inInit = (modelSweep < 32);
    lastG0 = 1'b0;
    lastG1 = 1'b0;
    if (!inInit) begin
      if (w0_valid && w1_valid) begin
        lastG0 = !modelPtr;
        lastG1 = modelPtr;
      end else begin
        lastG0 = w0_valid;
        lastG1 = w1_valid;
      end
    end
    g  = lastG0 || lastG1;
    wa = lastG1 ? w1_addr : w0_addr;
    wd = lastG1 ? w1_data : w0_data;
    checkOutput("w0_ready", w0_ready, lastG0);
    checkOutput("w1_ready", w1_ready, lastG1);
    checkOutput("init_done", init_done, !inInit);
    if (inInit) begin
      checkOutput("sweep_wea", ram_wea, 1);
      checkOutput("sweep_addrw", ram_addrw, modelSweep);
      checkOutput("sweep_din", ram_din, 0);
    end else if (g) begin
      checkOutput("wr_wea", ram_wea, wa != 5'd0);
      if (wa != 5'd0) begin
        checkOutput("wr_addrw", ram_addrw, wa);
        checkOutput("wr_din", ram_din, wd);
      end
    end else begin
      checkOutput("idle_wea", ram_wea, 0);
    end
    checkOutput("ram_addr0", ram_addr0, r_addr0);
    checkOutput("ram_addr1", ram_addr1, r_addr1);
    checkOutput("ram_addr2", ram_addr2, r_addr2);
    checkOutput("r_data0", r_data0, modelRead(r_addr0, inInit, g, wa, wd));
    checkOutput("r_data1", r_data1, modelRead(r_addr1, inInit, g, wa, wd));
    checkOutput("r_data2", r_data2, modelRead(r_addr2, inInit, g, wa, wd));
    if (inInit) begin
      modelRegs[modelSweep] = '0;
      modelSweep++;
    end else begin
      if (g && wa != 5'd0) modelRegs[wa] = wd;
      if (w0_valid && w1_valid) modelPtr = !modelPtr;
    end
  endtask

  task automatic applyStimulus(input bit v0, input logic [4:0] a0, input logic [WIDTH-1:0] d0,
                               input bit v1, input logic [4:0] a1, input logic [WIDTH-1:0] d1,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    w0_valid = v0; w0_addr = a0; w0_data = d0;
    w1_valid = v1; w1_addr = a1; w1_data = d1;
    r_addr0 = ra0; r_addr1 = ra1; r_addr2 = ra2;
    #1;
    compareCycle();
  endtask

  task automatic idleStep(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    applyStimulus(0, 5'd0, '0, 0, 5'd0, '0, ra0, ra1, ra2);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_w0_ready", w0_ready, 0);
    checkOutput("rst_w1_ready", w1_ready, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_addrw", ram_addrw, 0);
    modelSweep = 0;
    modelPtr = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic randomStep();
    logic [4:0] a0, a1, ra [3];
    a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    for (int k = 0; k < 3; k++) begin
      case ($urandom_range(0, 3))
        0: ra[k] = a0;
        1: ra[k] = a1;
        2: ra[k] = 5'($urandom_range(0, 7));
        default: ra[k] = 5'($urandom);
      endcase
    end
    applyStimulus(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom, ra[0], ra[1], ra[2]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) modelRegs[i] = $urandom;
    doReset();

    // sweep with w0 requesting from cycle 10 onward
    for (int i = 0; i < 32; i++) begin
      applyStimulus(i >= 10, 5'd3, 32'hA5A5_0003, 0, 5'd0, '0, 5'(i), 5'd3, 5'd31);
      checkOutput("init_addrw_lit", ram_addrw, i);
      checkOutput("init_w0_ready_lit", w0_ready, 0);
    end
    applyStimulus(1, 5'd3, 32'hA5A5_0003, 0, 5'd0, '0, 5'd3, 5'd0, 5'd31);
    checkOutput("run1_w0_ready_lit", w0_ready, 1);
    checkOutput("run1_init_done_lit", init_done, 1);
    checkOutput("run1_bypass_lit", r_data0, 32'hA5A5_0003);
    checkOutput("run1_cleared_lit", r_data2, 0);

    // write-through bypass then RAM read-back
    applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, '0, 5'd5, 5'd3, 5'd0);
    checkOutput("bypass_lit", r_data0, 32'hDEAD_BEEF);
    idleStep(5'd5, 5'd3, 5'd0);
    checkOutput("readback_lit", r_data0, 32'hDEAD_BEEF);
    checkOutput("ram_dout0_lit", ram_dout0, 32'hDEAD_BEEF);
    checkOutput("idle_wea_lit", ram_wea, 0);

    // contended grants alternate starting with w0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 5'd1, 32'h1000 + i, 1, 5'd2, 32'h2000 + i, 5'd1, 5'd2, 5'd5);
      checkOutput("rr_w0_lit", w0_ready, (i % 2) == 0);
      checkOutput("rr_w1_lit", w1_ready, (i % 2) == 1);
    end

    // write to register 0 handshakes but is dropped
    applyStimulus(0, 5'd0, '0, 1, 5'd0, 32'h1234, 5'd1, 5'd0, 5'd2);
    checkOutput("r0_w1_ready_lit", w1_ready, 1);
    checkOutput("r0_wea_lit", ram_wea, 0);
    checkOutput("r0_rdata_lit", r_data1, 0);
    checkOutput("r1_lit", r_data0, 32'h1002);
    checkOutput("r2_lit", r_data2, 32'h2003);

    repeat (300) randomStep();

    // reset mid-sweep at count 17 restarts the full sweep
    doReset();
    for (int i = 0; i <= 17; i++) idleStep(5'd5, 5'd1, 5'd2);
    checkOutput("mid_sweep_addrw_lit", ram_addrw, 17);
    doReset();
    for (int i = 0; i < 32; i++) begin
      idleStep(5'd5, 5'd1, 5'd2);
      checkOutput("resweep_addrw_lit", ram_addrw, i);
      checkOutput("resweep_done_lit", init_done, 0);
    end
    idleStep(5'd5, 5'd1, 5'd2);
    checkOutput("resweep_done_hi_lit", init_done, 1);
    checkOutput("resweep_clear_lit", r_data0, 0);

    repeat (150) randomStep();

    // reset mid-RUN, then verify contents were cleared again
    doReset();
    repeat (33) idleStep(5'($urandom), 5'($urandom), 5'($urandom));
    repeat (150) randomStep();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning register data width in bits.
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports w0_valid/w1_valid  input  1 each  write request from writeback source 0/1.
REQ-005 SHALL have ports w0_ready/w1_ready  output  1 each  grant; a transfer occurs when valid and ready are both high.
REQ-006 SHALL have ports w0_addr/w1_addr  input  5 each  and w0_data/w1_data  input  WIDTH each  write target and write data.
REQ-007 SHALL have ports r_addr0/r_addr1/r_addr2  input  5 each  and r_data0/r_data1/r_data2  output  WIDTH each  architectural read ports.
REQ-008 SHALL have RAM-side ports ram_addr0/1/2  output  5, ram_addrw  output  5, ram_din  output  WIDTH, ram_wea  output  1, ram_dout0/1/2  input  WIDTH; the RAM has combinational read and a synchronous write.
REQ-009 SHALL have port init_done  output  1  high once the clear sweep has completed.

Function
REQ-010 SHALL implement a two-state FSM: INIT and RUN.
REQ-011 In INIT, SHALL drive ram_wea=1, ram_din=0, and ram_addrw=sweep counter, with the counter running 0..31 over 32 consecutive cycles; w0_ready and w1_ready SHALL be 0.
REQ-012 SHALL enter RUN on the clock edge that follows the counter=31 write, and SHALL set init_done=1 from that edge onward.
REQ-013 In RUN with exactly one valid requester, SHALL assert that requester's ready in the same cycle (combinational grant).
REQ-014 In RUN with both requesters valid, SHALL grant the requester selected by a 1-bit round-robin pointer; after each such contended grant, the pointer SHALL move to the other requester.
REQ-015 An uncontended grant SHALL leave the pointer unchanged.
REQ-016 At most one ready SHALL be high per cycle.
REQ-017 A granted write SHALL drive ram_addrw/ram_din from the winner and set ram_wea=1 in the same cycle, except for address 0: the handshake completes but ram_wea=0.
REQ-018 ram_addrN SHALL equal r_addrN at all times.
REQ-019 If r_addrN is 0, r_dataN SHALL be 0.
REQ-020 Otherwise, if a RUN-state write to the same nonzero address is granted in the same cycle, r_dataN SHALL equal that write data (write-through bypass).
REQ-021 In all other cases, r_dataN SHALL equal ram_doutN.
REQ-022 During INIT, r_dataN SHALL be 0 for every address.
REQ-023 With no valid requester in RUN, ram_wea SHALL be 0.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force: state INIT, sweep counter 0, pointer selecting requester 0, init_done=0, both ready=0.
REQ-025 Reset asserted mid-sweep or mid-RUN SHALL restart the full 32-cycle sweep after deassertion; in-flight requests are not retained.
REQ-026 rst_n SHALL be used directly as the asynchronous reset of every flop; external logic guarantees synchronous deassertion.

Structure
REQ-027 The FSM state enum and the constants REG_CNT=32 and REG_ADDR_W=5 SHALL reside in the shared core package.
REQ-028 The round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs: two requests and the pointer; output: one-hot grant).
REQ-029 The RAM SHALL be instantiated outside this block.
REQ-030 Total RTL SHALL be 120-400 lines.

Verification
REQ-031 Reset then idle: ram_wea=1 with ram_addrw stepping 0..31 for 32 cycles; init_done rises on the following edge; both ready remain 0 throughout.
REQ-032 In RUN, w0 writes addr 5 with 0xDEADBEEF while r_addr0=5: r_data0=0xDEADBEEF in that same cycle, and on the next cycle r_data0 equals ram_dout0 = 0xDEADBEEF.
REQ-033 Both requesters valid for 4 cycles, pointer starting at 0: grants go w0, w1, w0, w1.
REQ-034 w1 writes addr 0 with 0x1234: w1_ready=1, ram_wea=0, and r_data1 with r_addr1=0 reads 0.
REQ-035 rst_n pulsed low at sweep count 17: init_done=0 and the sweep restarts at address 0, with 32 writes before init_done=1.
REQ-036 At cycle 10 of INIT, w0_valid=1: w0_ready stays 0 until the first RUN cycle, when it goes high.
